// File: rtl/ahb_sram_slave_pkg.sv
// ahb_sram_slave_pkg
//   Shared definitions for the AHB-Lite SRAM slave: AHB size/response encodings,
//   FSM state type and the byte-lane helper functions used by the slave.
package ahb_sram_slave_pkg;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } sram_state_e;

   // Byte-lane enable for a transfer; little-endian lane numbering.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
      logic [3:0] m;
      m = 4'b0000;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << addr;
         HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: m = 4'b1111;
         default:    m = 4'b0000;
      endcase
      return m;
   endfunction

   // Alignment violation for half/word transfers (byte is always aligned).
   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr);
      logic bad;
      bad = 1'b0;
      case (size)
         HSIZE_HALF: bad = addr[0];
         HSIZE_WORD: bad = (addr != 2'b00);
         default:    bad = 1'b0;
      endcase
      return bad;
   endfunction

   // Replace the lanes selected by mask in base with the lanes of upd.
   function automatic logic [31:0] merge_lanes(input logic [31:0] base, input logic [31:0] upd,
                                               input logic [3:0] mask);
      logic [31:0] r;
      r = base;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) begin
            r[8*b +: 8] = upd[8*b +: 8];
         end else begin
            r[8*b +: 8] = base[8*b +: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem
//   2**AW x 32-bit word array with a byte-enabled write port and a registered
//   read port. The read register only loads on re, so it holds between reads.
//   The array itself has no reset; only the read register is reset.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (read register only)
//   re, raddr   read enable / word address (data appears after the clock edge)
//   we, waddr   per-byte write enable / word address
//   wdata       write data
//   rdata       registered read data
module ahb_sram_mem
   import ahb_sram_slave_pkg::*;
#(
   parameter int AW        = 10,
   parameter int INIT_ZERO = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   localparam int DEPTH = 2**AW;

   // INIT_ZERO selects the power-up content of the array: all zeros or unknown.
   logic [31:0] mem_q [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx};
   logic [31:0] rdata_q;

   // Byte-lane writes into the array.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Registered read; old contents are returned when a write hits the same word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= 32'h0000_0000;
      end else if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite SRAM slave with byte/half/word access, WAIT_STATES ready-low cycles
//   per OKAY data phase and a two-cycle ERROR response for illegal transfers
//   (HSIZE>2, misaligned, or a privileged-region violation).
// Optional feature macro: AHB_SRAM_PRIV_EN -- user-mode (HPROT[1]=0) writes to
//   the lowest quarter of the array get ERROR and are not written.
// Ports: HCLK/HRESET (async active-high), AHB-Lite address/control inputs
//   (HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADYin),
//   HWDATA; registered outputs HREADYout, HRESP, HRDATA.
module ahb_sram_slave
   import ahb_sram_slave_pkg::*;
#(
   parameter int AW          = 10,
   parameter int WAIT_STATES = 0,
   parameter int INIT_ZERO   = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [1:0]  HTRANS,
   input  logic        HMASTLOCK,
   input  logic        HREADYin,
   input  logic [31:0] HWDATA,
   output logic        HREADYout,
   output logic        HRESP,
   output logic [31:0] HRDATA
);
   sram_state_e   state_q, state_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic          hready_q, hready_d;
   logic          hresp_q, hresp_d;
   logic          pend_wr_q, pend_wr_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [3:0]    wmask_q, wmask_d;
   logic [3:0]    fwd_mask_q, fwd_mask_d;
   logic [31:0]   fwd_data_q, fwd_data_d;

   logic          slot_free_s, accept_s, illegal_s, priv_err_s, rd_accept_s, commit_s;
   logic [AW-1:0] word_addr_s;
   logic [3:0]    lane_s, mem_we_s;
   logic [31:0]   mem_rdata_s;
   logic          unused_ok;

`ifdef AHB_SRAM_PRIV_EN
   // Lower quarter = top two word-address bits both zero.
   assign priv_err_s = HWRITE & ~HPROT[1] & (HADDR[AW+1:AW] == 2'b00);
   assign unused_ok  = ^{HBURST, HMASTLOCK, HPROT[3:2], HPROT[0], HTRANS[0], HADDR[31:AW+2]};
`else
   assign priv_err_s = 1'b0;
   assign unused_ok  = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0], HADDR[31:AW+2]};
`endif

   assign word_addr_s = HADDR[AW+1:2];
   assign lane_s      = lane_mask(HSIZE, HADDR[1:0]);
   assign illegal_s   = (HSIZE > HSIZE_WORD) | misaligned(HSIZE, HADDR[1:0]) | priv_err_s;
   // A new address phase can only be taken in a cycle where this slave shows ready.
   assign slot_free_s = (state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2);
   assign accept_s    = HSEL & HREADYin & HTRANS[1] & slot_free_s;
   assign rd_accept_s = accept_s & ~illegal_s & ~HWRITE;
   assign commit_s    = (state_q == ST_DATA) & pend_wr_q;
   assign mem_we_s    = commit_s ? wmask_q : 4'b0000;

   ahb_sram_mem #(
      .AW        (AW),
      .INIT_ZERO (INIT_ZERO)
   ) u_mem (
      .clk   (HCLK),
      .rst   (HRESET),
      .re    (rd_accept_s),
      .raddr (word_addr_s),
      .we    (mem_we_s),
      .waddr (waddr_q),
      .wdata (HWDATA),
      .rdata (mem_rdata_s)
   );

   // Next-state, wait counter, captured write control and registered response.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      pend_wr_d = pend_wr_q;
      waddr_d   = waddr_q;
      wmask_d   = wmask_q;
      case (state_q)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            // Any write in DATA commits at this edge, so the pending flag drops here.
            pend_wr_d = 1'b0;
            if (accept_s) begin
               if (illegal_s) begin
                  state_d = ST_ERR1;
               end else begin
                  pend_wr_d = HWRITE;
                  waddr_d   = word_addr_s;
                  wmask_d   = lane_s;
                  if (WAIT_STATES > 0) begin
                     state_d = ST_WAIT;
                     wcnt_d  = 4'(WAIT_STATES - 1);
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wcnt_q == 4'd0) begin
               state_d = ST_DATA;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase

      if ((state_d == ST_WAIT) || (state_d == ST_ERR1)) begin
         hready_d = 1'b0;
      end else begin
         hready_d = 1'b1;
      end
      if ((state_d == ST_ERR1) || (state_d == ST_ERR2)) begin
         hresp_d = HRESP_ERROR;
      end else begin
         hresp_d = HRESP_OKAY;
      end
   end

   // Read-after-write forwarding: when a read is accepted on the edge a write to the
   // same word commits, the array returns the old word, so remember the new lanes.
   always_comb begin
      fwd_mask_d = fwd_mask_q;
      fwd_data_d = fwd_data_q;
      if (rd_accept_s) begin
         fwd_data_d = HWDATA;
         if (commit_s && (waddr_q == word_addr_s)) begin
            fwd_mask_d = wmask_q;
         end else begin
            fwd_mask_d = 4'b0000;
         end
      end else begin
         fwd_mask_d = fwd_mask_q;
      end
   end

   // FSM and control state registers.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= ST_IDLE;
         wcnt_q     <= 4'd0;
         hready_q   <= 1'b1;
         hresp_q    <= HRESP_OKAY;
         pend_wr_q  <= 1'b0;
         waddr_q    <= '0;
         wmask_q    <= 4'b0000;
         fwd_mask_q <= 4'b0000;
         fwd_data_q <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         hready_q   <= hready_d;
         hresp_q    <= hresp_d;
         pend_wr_q  <= pend_wr_d;
         waddr_q    <= waddr_d;
         wmask_q    <= wmask_d;
         fwd_mask_q <= fwd_mask_d;
         fwd_data_q <= fwd_data_d;
      end
   end

   assign HREADYout = hready_q;
   assign HRESP     = hresp_q;
   // Both operands are flop outputs, so HRDATA holds whenever neither reloads.
   assign HRDATA    = merge_lanes(mem_rdata_s, fwd_data_q, fwd_mask_q);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
//   Two slaves on one bus: dut0 with no wait states, dut1 with two. The driver
//   issues pipelined transfers and queues the expected response; a monitor
//   follows each data phase and compares when the slave completes it.
module tb_ahb_sram_slave;
   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        hsel0, hsel1;
   logic [31:0] HADDR, HWDATA;
   logic        HWRITE, HMASTLOCK;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        rdy0, rdy1, resp0, resp1, hready_bus;
   logic [31:0] rdata0, rdata1;

   localparam logic [3:0] P_PRIV = 4'b0011;
   localparam logic [3:0] P_USER = 4'b0001;

   assign hready_bus = rdy0 & rdy1;

   always #5 HCLK = ~HCLK;

   ahb_sram_slave #(.AW(10), .WAIT_STATES(0), .INIT_ZERO(1)) dut0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
      .HREADYin(hready_bus), .HWDATA(HWDATA), .HREADYout(rdy0), .HRESP(resp0), .HRDATA(rdata0));

   ahb_sram_slave #(.AW(10), .WAIT_STATES(2), .INIT_ZERO(1)) dut1 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel1), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
      .HREADYin(hready_bus), .HWDATA(HWDATA), .HREADYout(rdy1), .HRESP(resp1), .HRDATA(rdata1));

   typedef struct {
      int          id;
      int          dut;
      logic        is_rd;
      logic [31:0] data;
      logic        resp;
      int          waits;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   logic dp_active = 1'b0;
   int   dp_dut = 0;
   int   lowcnt = 0;
   logic low_resp = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Monitor: follow the data phase of each accepted transfer and score it on completion.
   initial begin
      forever begin
         exp_t        e;
         logic        r;
         logic        rs;
         logic [31:0] rd;
         @(negedge HCLK);
         if (HRESET) begin
            dp_active = 1'b0;
            lowcnt    = 0;
            low_resp  = 1'b0;
         end else begin
            if (dp_active) begin
               r  = (dp_dut == 1) ? rdy1 : rdy0;
               rs = (dp_dut == 1) ? resp1 : resp0;
               rd = (dp_dut == 1) ? rdata1 : rdata0;
               if (!r) begin
                  lowcnt++;
                  if (rs) low_resp = 1'b1;
                  if (lowcnt > 20) begin
                     check("ready_timeout", 32'(lowcnt), 32'd0);
                     dp_active = 1'b0;
                  end
               end else if (sbq.size() == 0) begin
                  check("unexpected_phase", 32'd1, 32'd0);
                  dp_active = 1'b0;
               end else begin
                  e = sbq.pop_front();
                  check($sformatf("t%0d_dut", e.id), 32'(dp_dut), 32'(e.dut));
                  check($sformatf("t%0d_waits", e.id), 32'(lowcnt), 32'(e.waits));
                  check($sformatf("t%0d_lowresp", e.id), {31'd0, low_resp}, {31'd0, e.resp});
                  check($sformatf("t%0d_resp", e.id), {31'd0, rs}, {31'd0, e.resp});
                  if (e.is_rd) check($sformatf("t%0d_rdata", e.id), rd, e.data);
                  dp_active = 1'b0;
               end
            end
            if ((hsel0 | hsel1) && HTRANS[1] && hready_bus) begin
               dp_active = 1'b1;
               dp_dut    = hsel1 ? 1 : 0;
               lowcnt    = 0;
               low_resp  = 1'b0;
            end
         end
      end
   end

   // Address phase of one transfer; returns just after the accepting edge with
   // the write data for its data phase on HWDATA and the bus otherwise idle.
   task automatic issue(input int d, input int id, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] prot,
                        input logic err, input logic [31:0] exp_rd);
      exp_t e;
      int   guard;
      e.id = id; e.dut = d; e.is_rd = !wr && !err; e.data = exp_rd; e.resp = err;
      e.waits = err ? 1 : ((d == 1) ? 2 : 0);
      sbq.push_back(e);
      hsel0 = (d == 0); hsel1 = (d == 1);
      HADDR = a; HWRITE = wr; HSIZE = sz; HPROT = prot; HTRANS = 2'b10;
      guard = 0;
      @(negedge HCLK);
      while (!hready_bus && guard < 50) begin
         guard++;
         @(negedge HCLK);
      end
      if (!hready_bus) check($sformatf("t%0d_accept_timeout", id), 32'd0, 32'd1);
      @(posedge HCLK);
      #1;
      HWDATA = wd; hsel0 = 1'b0; hsel1 = 1'b0; HTRANS = 2'b00;
   endtask

   task automatic idle(input int n);
      hsel0 = 1'b0; hsel1 = 1'b0; HTRANS = 2'b00;
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESET = 1'b1; hsel0 = 1'b0; hsel1 = 1'b0; HADDR = 32'h0; HWDATA = 32'h0;
      HWRITE = 1'b0; HSIZE = 3'd2; HBURST = 3'd0; HPROT = P_PRIV; HTRANS = 2'b00;
      HMASTLOCK = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_ready0", {31'd0, rdy0}, 32'd1);
      check("rst_resp0", {31'd0, resp0}, 32'd0);
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_ready1", {31'd0, rdy1}, 32'd1);
      check("rst_resp1", {31'd0, resp1}, 32'd0);
      check("rst_rdata1", rdata1, 32'h0);
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;

      // T1: word write then immediate word read (forwarded)
      issue(0, 1, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, P_PRIV, 1'b0, 32'h0);
      issue(0, 2, 1'b0, 32'h10, 3'd2, 32'h0, P_PRIV, 1'b0, 32'hDEAD_BEEF);
      // T2: back-to-back byte writes, read right after the last one
      issue(0, 3, 1'b1, 32'h20, 3'd0, 32'h0000_0011, P_PRIV, 1'b0, 32'h0);
      issue(0, 4, 1'b1, 32'h21, 3'd0, 32'h0000_2200, P_PRIV, 1'b0, 32'h0);
      issue(0, 5, 1'b1, 32'h22, 3'd0, 32'h0033_0000, P_PRIV, 1'b0, 32'h0);
      issue(0, 6, 1'b1, 32'h23, 3'd0, 32'h4400_0000, P_PRIV, 1'b0, 32'h0);
      issue(0, 7, 1'b0, 32'h20, 3'd2, 32'h0, P_PRIV, 1'b0, 32'h4433_2211);
      // upper halfword and low byte merging into one word
      issue(0, 8, 1'b1, 32'h26, 3'd1, 32'hCAFE_0000, P_PRIV, 1'b0, 32'h0);
      issue(0, 9, 1'b0, 32'h24, 3'd2, 32'h0, P_PRIV, 1'b0, 32'hCAFE_0000);
      issue(0, 10, 1'b1, 32'h24, 3'd0, 32'h0000_005A, P_PRIV, 1'b0, 32'h0);
      issue(0, 11, 1'b0, 32'h24, 3'd2, 32'h0, P_PRIV, 1'b0, 32'hCAFE_005A);
      // upper address bits ignored
      issue(0, 12, 1'b1, 32'hFFFF_F050, 3'd2, 32'h0BAD_F00D, P_PRIV, 1'b0, 32'h0);
      issue(0, 13, 1'b0, 32'h0000_0050, 3'd2, 32'h0, P_PRIV, 1'b0, 32'h0BAD_F00D);
      idle(2);
      issue(0, 14, 1'b0, 32'h10, 3'd2, 32'h0, P_PRIV, 1'b0, 32'hDEAD_BEEF);
      // T4: illegal transfers leave the array untouched
      issue(0, 15, 1'b1, 32'h30, 3'd2, 32'h1234_5678, P_PRIV, 1'b0, 32'h0);
      issue(0, 16, 1'b1, 32'h31, 3'd1, 32'hFFFF_FFFF, P_PRIV, 1'b1, 32'h0);
      issue(0, 17, 1'b0, 32'h30, 3'd3, 32'hFFFF_FFFF, P_PRIV, 1'b1, 32'h0);
      issue(0, 18, 1'b1, 32'h32, 3'd2, 32'hFFFF_FFFF, P_PRIV, 1'b1, 32'h0);
      issue(0, 19, 1'b0, 32'h30, 3'd2, 32'h0, P_PRIV, 1'b0, 32'h1234_5678);
      idle(3);

      // T3: two wait states, pipelined reads
      issue(1, 20, 1'b1, 32'h08, 3'd2, 32'h55AA_55AA, P_PRIV, 1'b0, 32'h0);
      issue(1, 21, 1'b0, 32'h08, 3'd2, 32'h0, P_PRIV, 1'b0, 32'h55AA_55AA);
      issue(1, 22, 1'b0, 32'h10, 3'd2, 32'h0, P_PRIV, 1'b0, 32'h0);
      issue(1, 23, 1'b0, 32'h08, 3'd2, 32'h0, P_PRIV, 1'b0, 32'h55AA_55AA);
      idle(5);

      // T5: reset during the wait states of a write
      issue(1, 24, 1'b1, 32'h40, 3'd2, 32'h1111_2222, P_PRIV, 1'b0, 32'h0);
      idle(5);
      hsel1 = 1'b1; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd2; HPROT = P_PRIV; HTRANS = 2'b10;
      @(negedge HCLK);
      check("t5_ready_before", {31'd0, hready_bus}, 32'd1);
      @(posedge HCLK);
      #1;
      HWDATA = 32'h9999_9999; hsel1 = 1'b0; HTRANS = 2'b00;
      @(negedge HCLK);
      check("t5_in_wait", {31'd0, rdy1}, 32'd0);
      #2;
      HRESET = 1'b1;
      #1;
      check("t5_rst_ready", {31'd0, rdy1}, 32'd1);
      check("t5_rst_resp", {31'd0, resp1}, 32'd0);
      check("t5_rst_rdata", rdata1, 32'h0);
      @(negedge HCLK);
      #2;
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;
      issue(1, 25, 1'b0, 32'h40, 3'd2, 32'h0, P_PRIV, 1'b0, 32'h1111_2222);
      idle(5);

`ifdef AHB_SRAM_PRIV_EN
      // T6: user writes to the lowest quarter are rejected
      issue(0, 26, 1'b1, 32'h0, 3'd2, 32'hBADB_AD00, P_USER, 1'b1, 32'h0);
      issue(0, 27, 1'b0, 32'h0, 3'd2, 32'h0, P_USER, 1'b0, 32'h0);
      issue(0, 28, 1'b1, 32'h0, 3'd2, 32'h600D_CAFE, P_PRIV, 1'b0, 32'h0);
      issue(0, 29, 1'b0, 32'h0, 3'd2, 32'h0, P_USER, 1'b0, 32'h600D_CAFE);
      issue(0, 30, 1'b1, 32'h800, 3'd2, 32'h0000_0ABC, P_USER, 1'b0, 32'h0);
      issue(0, 31, 1'b0, 32'h800, 3'd2, 32'h0, P_USER, 1'b0, 32'h0000_0ABC);
`else
      // Without the privilege feature a user write to the lowest word is accepted.
      issue(0, 26, 1'b1, 32'h0, 3'd2, 32'hBADB_AD00, P_USER, 1'b0, 32'h0);
      issue(0, 27, 1'b0, 32'h0, 3'd2, 32'h0, P_USER, 1'b0, 32'hBADB_AD00);
`endif
      idle(5);

      check("sb_empty", 32'(sbq.size()), 32'd0);
      check("dp_idle", {31'd0, dp_active}, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
